// File: rtl/usb_multi_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : usb_multi_packet_fifo
//  Purpose  : Single-clock packet FIFO for the USB in-band path. Holds
//             2^NUM_PKTS_LOG2 fixed-length slots of 2^PKT_WORDS_LOG2 words.
//             A slot is committed only when its last word is written; a
//             partial slot can be aborted. The read side streams committed
//             packets word by word or drops the head packet whole.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_in      in   rising-edge clock
//    reset         in   synchronous, active-high
//    data_in       in   write data
//    write_enable  in   write data_in into the current slot
//    write_abort   in   discard the partially written slot
//    have_space    out  current write slot is free
//    read_enable   in   consume one word of the head packet
//    skip_packet   in   release the head packet immediately
//    data_out      out  registered read data (1-cycle latency)
//    data_valid    out  data_out was loaded this cycle
//    pkt_waiting   out  at least one committed packet present
//    pkt_count     out  number of committed packets
//    clear_errors  in   clears overrun / underrun
//    overrun       out  sticky: write attempted while full
//    underrun      out  sticky: read/skip attempted while empty
// ============================================================================
module usb_multi_packet_fifo #(
   parameter int DATA_WIDTH     = 16,
   parameter int PKT_WORDS_LOG2 = 8,
   parameter int NUM_PKTS_LOG2  = 2
) (
   input  logic                     clock_in,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     write_enable,
   input  logic                     write_abort,
   output logic                     have_space,
   input  logic                     read_enable,
   input  logic                     skip_packet,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     data_valid,
   output logic                     pkt_waiting,
   output logic [NUM_PKTS_LOG2:0]   pkt_count,
   input  logic                     clear_errors,
   output logic                     overrun,
   output logic                     underrun
);

   localparam int c_ADDR_WIDTH = PKT_WORDS_LOG2 + NUM_PKTS_LOG2;
   localparam int c_DEPTH      = 1 << c_ADDR_WIDTH;

   localparam logic [NUM_PKTS_LOG2:0]  c_NUM_PACKETS = {1'b1, {NUM_PKTS_LOG2{1'b0}}};
   localparam logic [NUM_PKTS_LOG2:0]  c_COUNT_ONE   = (NUM_PKTS_LOG2+1)'(1);
   localparam logic [NUM_PKTS_LOG2-1:0] c_PKT_ONE    = NUM_PKTS_LOG2'(1);
   localparam logic [PKT_WORDS_LOG2-1:0] c_OFF_ONE   = PKT_WORDS_LOG2'(1);
   localparam logic [PKT_WORDS_LOG2-1:0] c_OFF_LAST  = {PKT_WORDS_LOG2{1'b1}};

   logic [DATA_WIDTH-1:0]     r_mem [c_DEPTH];

   logic [NUM_PKTS_LOG2-1:0]  r_wr_pkt;
   logic [PKT_WORDS_LOG2-1:0] r_wr_off;
   logic [NUM_PKTS_LOG2-1:0]  r_rd_pkt;
   logic [PKT_WORDS_LOG2-1:0] r_rd_off;

   logic                      w_wr_do;
   logic                      w_commit;
   logic                      w_skip;
   logic                      w_rd_do;
   logic                      w_release;
   logic                      w_overrun_evt;
   logic                      w_underrun_evt;
   logic [NUM_PKTS_LOG2:0]    w_count_next;

   // have_space / pkt_waiting are registered copies of the count status, so
   // they are always consistent with pkt_count and usable as gates here.
   assign w_wr_do        = write_enable & have_space & ~write_abort;
   assign w_commit       = w_wr_do & (r_wr_off == c_OFF_LAST);
   assign w_skip         = skip_packet & pkt_waiting;
   assign w_rd_do        = read_enable & ~skip_packet & pkt_waiting;
   assign w_release      = w_skip | (w_rd_do & (r_rd_off == c_OFF_LAST));
   assign w_overrun_evt  = write_enable & ~have_space;
   assign w_underrun_evt = (read_enable | skip_packet) & ~pkt_waiting;

   // A commit and a release in the same cycle cancel out.
   always_comb begin
      w_count_next = pkt_count;
      case ({w_commit, w_release})
         2'b10:   w_count_next = pkt_count + c_COUNT_ONE;
         2'b01:   w_count_next = pkt_count - c_COUNT_ONE;
         default: w_count_next = pkt_count;
      endcase
   end

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clock_in) begin
      if (w_wr_do && !reset) begin
         r_mem[{r_wr_pkt, r_wr_off}] <= data_in;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         r_wr_pkt    <= '0;
         r_wr_off    <= '0;
         r_rd_pkt    <= '0;
         r_rd_off    <= '0;
         pkt_count   <= '0;
         pkt_waiting <= 1'b0;
         have_space  <= 1'b1;
         data_out    <= '0;
         data_valid  <= 1'b0;
         overrun     <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         // Write side: abort rewinds the slot and suppresses any write.
         if (write_abort) begin
            r_wr_off <= '0;
         end else if (w_wr_do) begin
            r_wr_off <= r_wr_off + c_OFF_ONE;
            if (w_commit) begin
               r_wr_pkt <= r_wr_pkt + c_PKT_ONE;
            end
         end

         // Read side: skip wins over read_enable.
         data_valid <= w_rd_do;
         if (w_skip) begin
            r_rd_off <= '0;
            r_rd_pkt <= r_rd_pkt + c_PKT_ONE;
         end else if (w_rd_do) begin
            data_out <= r_mem[{r_rd_pkt, r_rd_off}];
            r_rd_off <= r_rd_off + c_OFF_ONE;
            if (r_rd_off == c_OFF_LAST) begin
               r_rd_pkt <= r_rd_pkt + c_PKT_ONE;
            end
         end

         pkt_count   <= w_count_next;
         pkt_waiting <= (w_count_next != '0);
         have_space  <= (w_count_next != c_NUM_PACKETS);

         // A new error in the same cycle as clear_errors keeps the flag set.
         overrun  <= w_overrun_evt  | (overrun  & ~clear_errors);
         underrun <= w_underrun_evt | (underrun & ~clear_errors);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_multi_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_multi_packet_fifo
//  Purpose  : Directed self-checking bench for usb_multi_packet_fifo with
//             default parameters (16-bit words, 256-word packets, 4 slots).
//  Revision : 1.0  initial release
// ============================================================================
module tb_usb_multi_packet_fifo;

   logic        clock_in = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        write_enable;
   logic        write_abort;
   logic        have_space;
   logic        read_enable;
   logic        skip_packet;
   logic [15:0] data_out;
   logic        data_valid;
   logic        pkt_waiting;
   logic [2:0]  pkt_count;
   logic        clear_errors;
   logic        overrun;
   logic        underrun;

   int n_checks = 0;
   int n_pass   = 0;

   usb_multi_packet_fifo #(
      .DATA_WIDTH     (16),
      .PKT_WORDS_LOG2 (8),
      .NUM_PKTS_LOG2  (2)
   ) dut (
      .clock_in     (clock_in),
      .reset        (reset),
      .data_in      (data_in),
      .write_enable (write_enable),
      .write_abort  (write_abort),
      .have_space   (have_space),
      .read_enable  (read_enable),
      .skip_packet  (skip_packet),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .pkt_waiting  (pkt_waiting),
      .pkt_count    (pkt_count),
      .clear_errors (clear_errors),
      .overrun      (overrun),
      .underrun     (underrun)
   );

   always #5 clock_in = ~clock_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic write_word(input logic [15:0] v);
      data_in      = v;
      write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
   endtask

   task automatic write_pkt(input logic [15:0] base);
      for (int i = 0; i < 256; i++) write_word(base + 16'(i));
   endtask

   task automatic skip();
      skip_packet = 1'b1;
      tick();
      skip_packet = 1'b0;
   endtask

   task automatic read_pkt(input logic [15:0] base, input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         read_enable = 1'b1;
         tick();
         if (data_valid !== 1'b1 || data_out !== base + 16'(i)) bad++;
      end
      read_enable = 1'b0;
      check(tag, bad, 0);
   endtask

   initial begin
      reset = 1'b1; data_in = '0; write_enable = 0; write_abort = 0;
      read_enable = 0; skip_packet = 0; clear_errors = 0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_count",    pkt_count,   0);
      check("rst_waiting",  pkt_waiting, 0);
      check("rst_space",    have_space,  1);
      check("rst_dout",     data_out,    0);
      check("rst_valid",    data_valid,  0);
      check("rst_overrun",  overrun,     0);
      check("rst_underrun", underrun,    0);

      // Single packet round trip; commit only on word 255
      for (int i = 0; i < 255; i++) write_word(16'(i));
      check("t1_partial_count", pkt_count, 0);
      check("t1_partial_wait",  pkt_waiting, 0);
      write_word(16'h00FF);
      check("t1_commit_count", pkt_count, 1);
      check("t1_commit_wait",  pkt_waiting, 1);
      read_pkt(16'h0000, "t1_read_data");
      check("t1_drained_count", pkt_count, 0);
      check("t1_drained_wait",  pkt_waiting, 0);
      tick();
      check("t1_idle_valid", data_valid, 0);
      check("t1_idle_hold",  data_out, 16'h00FF);

      // Fill all four slots, then overrun
      for (int k = 0; k < 4; k++) write_pkt(16'h1000 + 16'(k * 256));
      check("t2_full_count", pkt_count, 4);
      check("t2_full_space", have_space, 0);
      write_word(16'hDEAD);
      check("t2_overrun",       overrun, 1);
      check("t2_overrun_count", pkt_count, 4);
      read_pkt(16'h1000, "t2_read_pkt0");
      check("t2_after_read_count", pkt_count, 3);
      check("t2_after_read_space", have_space, 1);
      clear_errors = 1'b1; tick(); clear_errors = 1'b0;
      check("t2_overrun_clear", overrun, 0);
      skip(); skip(); skip();
      check("t2_skip_drain", pkt_count, 0);

      // Abort, including an abort on the would-be last word
      for (int i = 0; i < 100; i++) write_word(16'hB000 + 16'(i));
      write_abort = 1'b1; tick(); write_abort = 1'b0;
      check("t3_abort_count", pkt_count, 0);
      for (int i = 0; i < 255; i++) write_word(16'hC000 + 16'(i));
      data_in = 16'hC0FF; write_enable = 1'b1; write_abort = 1'b1;
      tick();
      write_enable = 1'b0; write_abort = 1'b0;
      check("t3_abort_last_count", pkt_count, 0);
      write_pkt(16'hA000);
      check("t3_one_pkt", pkt_count, 1);
      read_pkt(16'hA000, "t3_read_data");

      // Skip mid-packet; skip + read together
      write_pkt(16'h2000);
      write_pkt(16'h2100);
      read_enable = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      read_enable = 1'b0;
      check("t4_word9", data_out, 16'h2009);
      skip();
      check("t4_skip_count", pkt_count, 1);
      check("t4_skip_valid", data_valid, 0);
      read_enable = 1'b1; tick(); read_enable = 1'b0;
      check("t4_next_word0", data_out, 16'h2100);
      check("t4_next_valid", data_valid, 1);
      read_enable = 1'b1; skip_packet = 1'b1; tick();
      read_enable = 1'b0; skip_packet = 1'b0;
      check("t4_both_count", pkt_count, 0);
      check("t4_both_valid", data_valid, 0);
      check("t4_both_hold",  data_out, 16'h2100);
      write_pkt(16'h2200);
      read_pkt(16'h2200, "t4_read_after_skip");

      // Underrun on empty FIFO
      read_enable = 1'b1; tick(); read_enable = 1'b0;
      check("t5_underrun",  underrun, 1);
      check("t5_valid",     data_valid, 0);
      check("t5_hold",      data_out, 16'h22FF);
      check("t5_count",     pkt_count, 0);
      clear_errors = 1'b1; read_enable = 1'b1; tick();
      read_enable = 1'b0;
      check("t5_clear_vs_new", underrun, 1);
      tick(); clear_errors = 1'b0;
      check("t5_cleared", underrun, 0);

      // Twelve packets streamed through, wrapping slots several times
      for (int k = 0; k < 4; k++) write_pkt(16'h3000 + 16'(k * 256));
      for (int k = 4; k < 12; k++) begin
         read_pkt(16'h3000 + 16'((k - 4) * 256), "t6_wrap_read");
         write_pkt(16'h3000 + 16'(k * 256));
      end
      for (int k = 8; k < 12; k++) read_pkt(16'h3000 + 16'(k * 256), "t6_wrap_tail");
      check("t6_end_count", pkt_count, 0);

      // Same-cycle commit and release
      write_pkt(16'h4000);
      for (int i = 0; i < 255; i++) write_word(16'h4100 + 16'(i));
      data_in = 16'h41FF; write_enable = 1'b1; skip_packet = 1'b1;
      tick();
      write_enable = 1'b0; skip_packet = 1'b0;
      check("t7_same_count", pkt_count, 1);
      check("t7_same_wait",  pkt_waiting, 1);
      check("t7_same_space", have_space, 1);
      read_pkt(16'h4100, "t7_read");

      // Reset mid-write, then mid-read
      for (int i = 0; i < 50; i++) write_word(16'h6000 + 16'(i));
      reset = 1'b1; tick(); reset = 1'b0;
      check("t8_wr_rst_count", pkt_count, 0);
      check("t8_wr_rst_space", have_space, 1);
      write_pkt(16'h5000);
      read_enable = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      reset = 1'b1; tick(); reset = 1'b0; read_enable = 1'b0;
      check("t8_rd_rst_dout",  data_out, 0);
      check("t8_rd_rst_valid", data_valid, 0);
      check("t8_rd_rst_count", pkt_count, 0);
      check("t8_rd_rst_wait",  pkt_waiting, 0);
      check("t8_rd_rst_space", have_space, 1);
      check("t8_rd_rst_flags", {overrun, underrun}, 0);
      write_pkt(16'h5100);
      read_pkt(16'h5100, "t8_post_reset_read");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
